// File: rtl/wave_dispatch_sched_if.sv
// Bundle of the instruction handshake, the two trigger-queue FIFO ports
// and the playback trigger outputs of the wave dispatch scheduler.
interface wave_dispatch_sched_if #(
    parameter int TW = 8,
    parameter int DW = 16
);
    logic                 in_valid;
    logic [31:0]          in_instr;
    logic                 in_ready;
    logic [1:0]           wr_en;
    logic [DW+TW-1:0]     wr_data;
    logic [1:0]           full;
    logic [1:0]           rd_en;
    logic [DW+TW-1:0]     rd_data0;
    logic [DW+TW-1:0]     rd_data1;
    logic [1:0]           empty;
    logic [1:0]           trig_valid;
    logic [TW-1:0]        trig_word0;
    logic [TW-1:0]        trig_word1;
    logic [1:0]           busy;
    logic                 err;

    modport master (
        output in_valid, in_instr, full, rd_data0, rd_data1, empty,
        input  in_ready, wr_en, wr_data, rd_en, trig_valid, trig_word0, trig_word1, busy, err
    );

    modport slave (
        input  in_valid, in_instr, full, rd_data0, rd_data1, empty,
        output in_ready, wr_en, wr_data, rd_en, trig_valid, trig_word0, trig_word1, busy, err
    );
endinterface

// File: rtl/wave_dispatch_sched.sv
// Decodes fetched instructions into two trigger queues and plays each queue
// back as delayed one-cycle trigger strobes; SYNC stalls dispatch until both drain.
module wave_dispatch_sched #(
    parameter int TW = 8,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    wave_dispatch_sched_if.slave bus
);
    localparam int         EW      = DW + TW;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_SYNC = 4'h2;

    typedef enum logic {D_ACCEPT, D_SYNC_WAIT} disp_e;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_FIRE} sched_e;

    disp_e         disp_q, disp_d;
    logic          err_q, err_d;
    sched_e        st_q   [2];
    sched_e        st_d   [2];
    logic [DW-1:0] cnt_q  [2];
    logic [DW-1:0] cnt_d  [2];
    logic [TW-1:0] pend_q [2];
    logic [TW-1:0] pend_d [2];
    logic [TW-1:0] word_q [2];
    logic [TW-1:0] word_d [2];
    logic [EW-1:0] rd_data[2];

    logic [3:0] op;
    logic       sel;
    logic       in_ready;
    logic       hs;
    logic [1:0] wr_en;
    logic [1:0] rd_en;
    logic [1:0] fire;
    logic [1:0] busy;
    logic       unused_instr;

    assign op           = bus.in_instr[31:28];
    assign sel          = bus.in_instr[27];
    assign rd_data[0]   = bus.rd_data0;
    assign rd_data[1]   = bus.rd_data1;
    assign unused_instr = ^bus.in_instr;

    // Dispatch: PUSH is held off by the target queue's full flag, so in_ready
    // depends combinationally on the presented instruction.
    always_comb begin
        disp_d   = disp_q;
        err_d    = 1'b0;
        wr_en    = 2'b00;
        in_ready = ~rst & en & (disp_q == D_ACCEPT) & ~((op == OP_PUSH) & bus.full[sel]);
        hs       = bus.in_valid & in_ready;
        case (disp_q)
            D_ACCEPT: begin
                if (hs) begin
                    if (op == OP_PUSH) begin
                        wr_en[sel] = 1'b1;
                    end else if (op == OP_SYNC) begin
                        disp_d = D_SYNC_WAIT;
                    end else if (op != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            D_SYNC_WAIT: begin
                if ((bus.empty == 2'b11) && (busy == 2'b00)) begin
                    disp_d = D_ACCEPT;
                end
            end
        endcase
    end

    // Per-queue playback: pop, load delay, count down (frozen by en), strobe.
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            st_d[q]   = st_q[q];
            cnt_d[q]  = cnt_q[q];
            pend_d[q] = pend_q[q];
            word_d[q] = word_q[q];
            rd_en[q]  = 1'b0;
            fire[q]   = 1'b0;
            busy[q]   = (st_q[q] != S_IDLE);
            case (st_q[q])
                S_IDLE: begin
                    if (!bus.empty[q]) begin
                        rd_en[q] = 1'b1;
                        st_d[q]  = S_FETCH;
                    end
                end
                S_FETCH: begin
                    cnt_d[q]  = rd_data[q][EW-1:TW];
                    pend_d[q] = rd_data[q][TW-1:0];
                    st_d[q]   = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q[q] == '0) begin
                        st_d[q] = S_FIRE;
                    end else if (en) begin
                        cnt_d[q] = cnt_q[q] - DW'(1);
                    end
                end
                S_FIRE: begin
                    fire[q]   = 1'b1;
                    word_d[q] = pend_q[q];
                    if (!bus.empty[q]) begin
                        rd_en[q] = 1'b1;
                        st_d[q]  = S_FETCH;
                    end else begin
                        st_d[q] = S_IDLE;
                    end
                end
            endcase
            rd_en[q] = rd_en[q] & ~rst;
            fire[q]  = fire[q] & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= D_ACCEPT;
            err_q  <= 1'b0;
            for (int q = 0; q < 2; q++) begin
                st_q[q]   <= S_IDLE;
                cnt_q[q]  <= '0;
                pend_q[q] <= '0;
                word_q[q] <= '0;
            end
        end else begin
            disp_q <= disp_d;
            err_q  <= err_d;
            for (int q = 0; q < 2; q++) begin
                st_q[q]   <= st_d[q];
                cnt_q[q]  <= cnt_d[q];
                pend_q[q] <= pend_d[q];
                word_q[q] <= word_d[q];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en;
    assign bus.wr_data    = {bus.in_instr[DW+7:8], bus.in_instr[TW-1:0]};
    assign bus.rd_en      = rd_en;
    assign bus.trig_valid = fire;
    assign bus.trig_word0 = fire[0] ? pend_q[0] : word_q[0];
    assign bus.trig_word1 = fire[1] ? pend_q[1] : word_q[1];
    assign bus.busy       = busy;
    assign bus.err        = err_q;
endmodule
